// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues pipelined word requests and
// buffers in-order responses in a show-ahead prefetch queue feeding decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   sum_t;

    localparam cnt_t DEPTH_C  = cnt_t'(QUEUE_DEPTH);
    localparam sum_t CREDIT_C = sum_t'(QUEUE_DEPTH);

    logic [31:0] fetchPc;
    logic [31:0] tagPc;
    logic [31:0] alignedRedirect;
    logic [31:0] qData [QUEUE_DEPTH];
    logic [31:0] qPc   [QUEUE_DEPTH];
    ptr_t        rdPtr;
    ptr_t        wrPtr;
    cnt_t        count;
    cnt_t        outstanding;
    cnt_t        dropCnt;
    sum_t        inFlight;
    logic        reqFire;
    logic        rspDrop;
    logic        push;
    logic        pop;

    assign alignedRedirect = redirect_pc & 32'hFFFF_FFFC;
    assign inFlight        = sum_t'(count) + sum_t'(outstanding);

    always_comb begin
        imem_req_valid = rst_n & ~redirect_valid & (inFlight < CREDIT_C);
        imem_req_addr  = fetchPc;
        reqFire        = imem_req_valid & imem_req_ready;
        rspDrop        = imem_rsp_valid & (redirect_valid | (dropCnt != '0));
        push           = imem_rsp_valid & ~rspDrop;
        inst_valid     = rst_n & (count != '0);
        inst_data      = qData[rdPtr];
        inst_pc        = qPc[rdPtr];
        pop            = inst_valid & inst_ready & ~redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetchPc     <= RESET_PC;
            tagPc       <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(reqFire) - cnt_t'(imem_rsp_valid);
            if (redirect_valid) begin
                fetchPc <= alignedRedirect;
                tagPc   <= alignedRedirect;
                count   <= '0;
                rdPtr   <= '0;
                wrPtr   <= '0;
                // Pending drops are already part of outstanding, so after a redirect every
                // request still in flight is stale; this keeps back-to-back redirects exact.
                dropCnt <= outstanding - cnt_t'(imem_rsp_valid);
            end else begin
                if (reqFire) fetchPc <= fetchPc + 32'd4;
                if (push) begin
                    tagPc <= tagPc + 32'd4;
                    wrPtr <= wrPtr + ptr_t'(1);
                end
                if (pop) rdPtr <= rdPtr + ptr_t'(1);
                count <= count + cnt_t'(push) - cnt_t'(pop);
                if (rspDrop) dropCnt <= dropCnt - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            qData[wrPtr] <= imem_rsp_data;
            qPc[wrPtr]   <= tagPc;
        end
    end

    // The credit limit must make a push into a full queue impossible.
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) assert (count != DEPTH_C);
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomised and directed bench for inst_fetch_unit, scored against an epoch-tagged
// model of requests, in-order memory responses and the expected decode stream.
module tb_inst_fetch_unit;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] PC_A  = 32'h0000_0000;
    localparam logic [31:0] PC_B  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, sel, redirValid, reqReady, rspValid, instReady;
    logic [31:0] redirPc, rspData;
    logic        reqValidA, reqValidB, instValidA, instValidB;
    logic [31:0] reqAddrA, reqAddrB, instDataA, instDataB, instPcA, instPcB;
    logic        reqValid, instValid;
    logic [31:0] reqAddr, instData, instPc;

    inst_fetch_unit #(.RESET_PC(PC_A), .QUEUE_DEPTH(DEPTH)) dutA (
        .clk(clk), .rst_n(rstN & ~sel), .redirect_valid(redirValid), .redirect_pc(redirPc),
        .imem_req_valid(reqValidA), .imem_req_ready(reqReady), .imem_req_addr(reqAddrA),
        .imem_rsp_valid(rspValid), .imem_rsp_data(rspData), .inst_valid(instValidA),
        .inst_ready(instReady), .inst_data(instDataA), .inst_pc(instPcA)
    );

    inst_fetch_unit #(.RESET_PC(PC_B), .QUEUE_DEPTH(DEPTH)) dutB (
        .clk(clk), .rst_n(rstN & sel), .redirect_valid(redirValid), .redirect_pc(redirPc),
        .imem_req_valid(reqValidB), .imem_req_ready(reqReady), .imem_req_addr(reqAddrB),
        .imem_rsp_valid(rspValid), .imem_rsp_data(rspData), .inst_valid(instValidB),
        .inst_ready(instReady), .inst_data(instDataB), .inst_pc(instPcB)
    );

    assign reqValid  = sel ? reqValidB  : reqValidA;
    assign reqAddr   = sel ? reqAddrB   : reqAddrA;
    assign instValid = sel ? instValidB : instValidA;
    assign instData  = sel ? instDataB  : instDataA;
    assign instPc    = sel ? instPcB    : instPcA;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int          due;
    } req_t;

    req_t        mem[$];
    logic [31:0] mq[$];
    logic [31:0] fetchM;
    int unsigned epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    int          nChecks = 0;
    int          nFails = 0;
    string       curTest = "init";
    logic        obsReqValid, obsInstValid, popped, fired;
    logic [31:0] obsReqAddr, poppedPc;
    logic [31:0] pcs[8];
    int          gotPops;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive memory, score outputs against the model, advance the model.
    task automatic step();
        logic expReq, expValid, rsp, pop;
        rsp      = rstN && (mem.size() != 0) && (mem[0].due <= cyc);
        rspValid = rsp;
        rspData  = rsp ? memWord(mem[0].addr) : 32'h0;
        #1;
        expReq = rstN && !redirValid && ((mq.size() + mem.size()) < DEPTH);
        nChecks++;
        if (reqValid !== expReq) begin
            nFails++;
            $display("FAIL %s req_valid cyc %0d: got %b want %b", curTest, cyc, reqValid, expReq);
        end
        if (expReq) begin
            nChecks++;
            if (reqAddr !== fetchM) begin
                nFails++;
                $display("FAIL %s req_addr cyc %0d: got %h want %h", curTest, cyc, reqAddr, fetchM);
            end
        end
        expValid = rstN && (mq.size() != 0);
        nChecks++;
        if (instValid !== expValid) begin
            nFails++;
            $display("FAIL %s inst_valid cyc %0d: got %b want %b", curTest, cyc, instValid, expValid);
        end
        if (expValid && instValid === 1'b1) begin
            nChecks++;
            if (instPc !== mq[0] || instData !== memWord(mq[0])) begin
                nFails++;
                $display("FAIL %s inst cyc %0d: got pc %h data %h want pc %h data %h",
                         curTest, cyc, instPc, instData, mq[0], memWord(mq[0]));
            end
        end
        fired        = (reqValid === 1'b1) && reqReady;
        pop          = rstN && (instValid === 1'b1) && instReady && !redirValid;
        popped       = pop;
        poppedPc     = instPc;
        obsReqValid  = reqValid;
        obsReqAddr   = reqAddr;
        obsInstValid = instValid;
        @(posedge clk);
        if (!rstN) begin
            mem.delete();
            mq.delete();
            epoch++;
            fetchM = sel ? PC_B : PC_A;
        end else begin
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (rsp) begin
                req_t r;
                r = mem.pop_front();
                if (!redirValid && r.epoch == epoch) mq.push_back(r.addr);
            end
            if (redirValid) begin
                mq.delete();
                epoch++;
                fetchM = {redirPc[31:2], 2'b00};
            end else if (fired) begin
                mem.push_back('{fetchM, epoch, cyc + lat});
                fetchM = fetchM + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        redirValid = 1'b0;
        step();
        step();
        rstN = 1'b1;
    endtask

    task automatic collect(input int n);
        int guard;
        gotPops = 0;
        guard   = 0;
        while (gotPops < n && guard < 40) begin
            step();
            if (popped) begin
                pcs[gotPops] = poppedPc;
                gotPops++;
            end
            guard++;
        end
        nChecks++;
        if (gotPops != n) begin
            nFails++;
            $display("FAIL %s pop_timeout: got %0d pops want %0d", curTest, gotPops, n);
        end
    endtask

    task automatic test_reset();
        curTest = "reset";
        sel = 1'b0; lat = 1; reqReady = 1'b1; instReady = 1'b1;
        rstN = 1'b0; redirValid = 1'b1; redirPc = 32'h0000_0F00;
        step();
        step();
        rstN = 1'b1; redirValid = 1'b0;
        step();
        nChecks++;
        if (obsReqValid !== 1'b1 || obsReqAddr !== PC_A) begin
            nFails++;
            $display("FAIL reset first_req: got v=%b a=%h want v=1 a=%h", obsReqValid, obsReqAddr, PC_A);
        end
    endtask

    task automatic test_stream();
        curTest = "stream";
        sel = 1'b0; lat = 1; reqReady = 1'b1; instReady = 1'b1;
        doReset();
        for (int i = 0; i < 20; i++) begin
            step();
            nChecks++;
            if (obsInstValid !== (i >= 2)) begin
                nFails++;
                $display("FAIL stream valid_cycle %0d: got %b want %b", i, obsInstValid, i >= 2);
            end
            if (i >= 2) begin
                nChecks++;
                if (poppedPc !== PC_A + 32'(4 * (i - 2))) begin
                    nFails++;
                    $display("FAIL stream pc_cycle %0d: got %h want %h", i, poppedPc, PC_A + 32'(4 * (i - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nFire, nPop;
        logic [31:0] expPc;
        curTest = "backpressure";
        sel = 1'b0; lat = 1; reqReady = 1'b1; instReady = 1'b0;
        doReset();
        nFire = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (fired) nFire++;
        end
        nChecks++;
        if (nFire != 4 || obsReqValid !== 1'b0 || obsInstValid !== 1'b1) begin
            nFails++;
            $display("FAIL backpressure stall: got fires=%0d req=%b inst=%b want 4 0 1",
                     nFire, obsReqValid, obsInstValid);
        end
        instReady = 1'b1;
        nPop  = 0;
        expPc = PC_A;
        for (int i = 0; i < 12; i++) begin
            step();
            if (popped) begin
                nPop++;
                nChecks++;
                if (poppedPc !== expPc) begin
                    nFails++;
                    $display("FAIL backpressure order: got %h want %h", poppedPc, expPc);
                end
                expPc = expPc + 32'd4;
            end
        end
        nChecks++;
        if (nPop != 12) begin
            nFails++;
            $display("FAIL backpressure no_gap: got %0d pops want 12", nPop);
        end
    endtask

    task automatic test_redirect_latency();
        int guard;
        curTest = "redirect_lat3";
        sel = 1'b0; lat = 3; reqReady = 1'b1; instReady = 1'b1;
        doReset();
        guard = 0;
        while (mem.size() < 3 && guard < 10) begin
            step();
            guard++;
        end
        nChecks++;
        if (mem.size() != 3) begin
            nFails++;
            $display("FAIL redirect_lat3 outstanding: got %0d want 3", mem.size());
        end
        redirValid = 1'b1; redirPc = 32'h0000_0100;
        step();
        redirValid = 1'b0;
        step();
        nChecks++;
        if (obsInstValid !== 1'b0) begin
            nFails++;
            $display("FAIL redirect_lat3 valid_after: got %b want 0", obsInstValid);
        end
        collect(2);
        nChecks++;
        if (gotPops == 2 && (pcs[0] !== 32'h100 || pcs[1] !== 32'h104)) begin
            nFails++;
            $display("FAIL redirect_lat3 pcs: got %h %h want 00000100 00000104", pcs[0], pcs[1]);
        end
    endtask

    task automatic test_redirect_collide();
        curTest = "redirect_collide";
        sel = 1'b0; lat = 1; reqReady = 1'b1; instReady = 1'b1;
        doReset();
        for (int i = 0; i < 4; i++) step();
        redirValid = 1'b1; redirPc = 32'h0000_0203;
        step();
        redirValid = 1'b0;
        collect(2);
        nChecks++;
        if (gotPops == 2 && (pcs[0] !== 32'h200 || pcs[1] !== 32'h204)) begin
            nFails++;
            $display("FAIL redirect_collide pcs: got %h %h want 00000200 00000204", pcs[0], pcs[1]);
        end
    endtask

    task automatic test_back_to_back();
        curTest = "back_to_back";
        sel = 1'b0; lat = 3; reqReady = 1'b1; instReady = 1'b1;
        doReset();
        for (int i = 0; i < 3; i++) step();
        redirValid = 1'b1; redirPc = 32'h0000_0500;
        step();
        redirPc = 32'h0000_1000;
        step();
        redirValid = 1'b0;
        collect(3);
        nChecks++;
        if (gotPops == 3 && (pcs[0] !== 32'h1000 || pcs[1] !== 32'h1004 || pcs[2] !== 32'h1008)) begin
            nFails++;
            $display("FAIL back_to_back pcs: got %h %h %h want 00001000 00001004 00001008",
                     pcs[0], pcs[1], pcs[2]);
        end
    endtask

    task automatic test_wrap();
        curTest = "wrap";
        sel = 1'b1; lat = 1; reqReady = 1'b1; instReady = 1'b1;
        doReset();
        collect(3);
        nChecks++;
        if (gotPops == 3 && (pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0)) begin
            nFails++;
            $display("FAIL wrap pcs: got %h %h %h want fffffff8 fffffffc 00000000", pcs[0], pcs[1], pcs[2]);
        end
        sel = 1'b0;
        doReset();
    endtask

    task automatic test_reset_midflight();
        int guard;
        curTest = "reset_midflight";
        sel = 1'b0; lat = 3; reqReady = 1'b1; instReady = 1'b0;
        doReset();
        guard = 0;
        while ((mq.size() < 2 || mem.size() < 2) && guard < 20) begin
            step();
            guard++;
        end
        nChecks++;
        if (mq.size() < 2 || mem.size() < 2) begin
            nFails++;
            $display("FAIL reset_midflight setup: got q=%0d out=%0d want >=2 each", mq.size(), mem.size());
        end
        rstN = 1'b0;
        step();
        nChecks++;
        if (obsReqValid !== 1'b0 || obsInstValid !== 1'b0) begin
            nFails++;
            $display("FAIL reset_midflight during: got req=%b inst=%b want 0 0", obsReqValid, obsInstValid);
        end
        rstN = 1'b1;
        step();
        nChecks++;
        if (obsInstValid !== 1'b0 || obsReqValid !== 1'b1 || obsReqAddr !== PC_A) begin
            nFails++;
            $display("FAIL reset_midflight after: got inst=%b req=%b addr=%h want 0 1 %h",
                     obsInstValid, obsReqValid, obsReqAddr, PC_A);
        end
    endtask

    task automatic test_random();
        curTest = "random";
        sel = 1'b0;
        doReset();
        for (int i = 0; i < 600; i++) begin
            lat        = int'($urandom_range(1, 4));
            reqReady   = ($urandom_range(0, 3) != 0);
            instReady  = ($urandom_range(0, 9) < 7);
            redirValid = ($urandom_range(0, 19) == 0);
            redirPc    = $urandom;
            step();
        end
        redirValid = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; sel = 1'b0; redirValid = 1'b0; redirPc = 32'h0;
        reqReady = 1'b0; rspValid = 1'b0; rspData = 32'h0; instReady = 1'b0;
        fetchM = PC_A;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collide();
        test_back_to_back();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
